// File: rtl/lock_pkg.sv
// Shared types, defaults and width helpers for the lock key sequencer.
package lock_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } lock_state_e;

    localparam int unsigned DefKeyW      = 7;
    localparam int unsigned DefNumEpochs = 2;
    localparam int unsigned DefEpochLen  = 7;

    // Width of an epoch index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of the lock-period position counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned p);
        return (p <= 1) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/lock_epoch_counter.sv
// Nested in-epoch / epoch counters plus the flat lock-period position.
// epoch tracks cnt / EPOCH_LEN without a divider.
module lock_epoch_counter
    import lock_pkg::*;
#(
    parameter int unsigned NUM_EPOCHS = DefNumEpochs,
    parameter int unsigned EPOCH_LEN  = DefEpochLen,
    parameter int unsigned IDX_W      = idx_width(NUM_EPOCHS),
    parameter int unsigned CNT_W      = cnt_width(NUM_EPOCHS * EPOCH_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] epoch,
    output logic [IDX_W-1:0] epoch_next
);

    localparam int unsigned P    = NUM_EPOCHS * EPOCH_LEN;
    localparam int unsigned IN_W = idx_width(EPOCH_LEN);

    logic [IN_W-1:0]  in_q, in_d;
    logic [IDX_W-1:0] ep_q, ep_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: clear wins, otherwise step all counters with their wraps.
    always_comb begin
        in_d  = in_q;
        ep_d  = ep_q;
        cnt_d = cnt_q;
        if (clear) begin
            in_d  = '0;
            ep_d  = '0;
            cnt_d = '0;
        end else if (advance) begin
            if (in_q == IN_W'(EPOCH_LEN - 1)) begin
                in_d = '0;
                ep_d = (ep_q == IDX_W'(NUM_EPOCHS - 1)) ? '0 : ep_q + IDX_W'(1);
            end else begin
                in_d = in_q + IN_W'(1);
            end
            cnt_d = (cnt_q == CNT_W'(P - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_q  <= '0;
            ep_q  <= '0;
            cnt_q <= '0;
        end else begin
            in_q  <= in_d;
            ep_q  <= ep_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt        = cnt_q;
    assign epoch      = ep_q;
    assign epoch_next = ep_d;

endmodule

// File: rtl/lock_key_sequencer.sv
// Time-varying key scheduler: presents key[epoch] on the locked FSM's key
// inputs during each counter window and owns that FSM's reset.
module lock_key_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned KEY_W      = DefKeyW,
    parameter int unsigned NUM_EPOCHS = DefNumEpochs,
    parameter int unsigned EPOCH_LEN  = DefEpochLen,
    parameter int unsigned IDX_W      = idx_width(NUM_EPOCHS),
    parameter int unsigned CNT_W      = cnt_width(NUM_EPOCHS * EPOCH_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [KEY_W-1:0] cfg_key,
    output logic             cfg_err,
    input  logic             start,
    input  logic             stop,
    output logic             start_err,
    output logic [KEY_W-1:0] key_out,
    output logic             fsm_rst,
    output logic             running,
    output logic [IDX_W-1:0] epoch,
    output logic [CNT_W-1:0] cnt
);

    lock_state_e           state_q;
    logic [KEY_W-1:0]      key_q [NUM_EPOCHS];
    logic [NUM_EPOCHS-1:0] mask_q;

    logic             idx_ok;
    logic             wr_en;
    logic             advance;
    logic             clear;
    logic [IDX_W-1:0] epoch_next;
    logic [KEY_W-1:0] key_sel;

    assign idx_ok  = 32'(cfg_idx) < NUM_EPOCHS;
    assign wr_en   = (state_q == StIdle) && cfg_valid && idx_ok;
    assign advance = (state_q == StRun) && !stop;
    assign clear   = (state_q == StRun) && stop;

    lock_epoch_counter #(
        .NUM_EPOCHS (NUM_EPOCHS),
        .EPOCH_LEN  (EPOCH_LEN),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W)
    ) u_epoch_counter (
        .clk        (clk),
        .rst        (rst),
        .advance    (advance),
        .clear      (clear),
        .cnt        (cnt),
        .epoch      (epoch),
        .epoch_next (epoch_next)
    );

    // Key for the upcoming window; a same-edge rewrite of that slot is forwarded
    // so key_out never lags the key store.
    always_comb begin
        key_sel = key_q[epoch_next];
        if (wr_en && (cfg_idx == epoch_next)) begin
            key_sel = cfg_key;
        end
    end

    // Key store and loaded mask; writable only while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_EPOCHS; i++) begin
                key_q[i] <= '0;
            end
            mask_q <= '0;
        end else if (wr_en) begin
            key_q[cfg_idx]  <= cfg_key;
            mask_q[cfg_idx] <= 1'b1;
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cfg_ready <= 1'b1;
            fsm_rst   <= 1'b1;
            running   <= 1'b0;
            key_out   <= '0;
            cfg_err   <= 1'b0;
            start_err <= 1'b0;
        end else begin
            cfg_err   <= 1'b0;
            start_err <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cfg_valid && !idx_ok) begin
                        cfg_err <= 1'b1;
                    end
                    // Mask is the registered one: a same-edge write does not count.
                    if (start && !stop) begin
                        if (&mask_q) begin
                            state_q   <= StRun;
                            cfg_ready <= 1'b0;
                            fsm_rst   <= 1'b0;
                            running   <= 1'b1;
                            key_out   <= key_sel;
                        end else begin
                            start_err <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_q   <= StIdle;
                        cfg_ready <= 1'b1;
                        fsm_rst   <= 1'b1;
                        running   <= 1'b0;
                        key_out   <= '0;
                    end else begin
                        key_out <= key_sel;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_key_sequencer.sv
// Scoreboard bench for lock_key_sequencer: the stimulus process updates a
// behavioural model and queues expected outputs; a negedge monitor compares.
module tb_lock_key_sequencer;

    localparam int unsigned KW = 7;
    localparam int unsigned N  = 2;
    localparam int unsigned L  = 7;
    localparam int unsigned P  = N * L;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [0:0] cfg_idx = '0;
    logic [6:0] cfg_key = '0;
    logic       cfg_err;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       start_err;
    logic [6:0] key_out;
    logic       fsm_rst;
    logic       running;
    logic [0:0] epoch;
    logic [3:0] cnt;

    // Second instance with a non-power-of-two epoch count for index range checks.
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [1:0] b_idx = '0;
    logic [3:0] b_key = '0;
    logic       b_cfg_err;
    logic       b_start = 1'b0;
    logic       b_start_err;
    logic [3:0] b_key_out;
    logic       b_fsm_rst;
    logic       b_running;
    logic [1:0] b_epoch;
    logic [2:0] b_cnt;

    always #5 clk = ~clk;

    lock_key_sequencer #(
        .KEY_W      (KW),
        .NUM_EPOCHS (N),
        .EPOCH_LEN  (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_idx   (cfg_idx),
        .cfg_key   (cfg_key),
        .cfg_err   (cfg_err),
        .start     (start),
        .stop      (stop),
        .start_err (start_err),
        .key_out   (key_out),
        .fsm_rst   (fsm_rst),
        .running   (running),
        .epoch     (epoch),
        .cnt       (cnt)
    );

    lock_key_sequencer #(
        .KEY_W      (4),
        .NUM_EPOCHS (3),
        .EPOCH_LEN  (2)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (b_valid),
        .cfg_ready (b_ready),
        .cfg_idx   (b_idx),
        .cfg_key   (b_key),
        .cfg_err   (b_cfg_err),
        .start     (b_start),
        .stop      (1'b0),
        .start_err (b_start_err),
        .key_out   (b_key_out),
        .fsm_rst   (b_fsm_rst),
        .running   (b_running),
        .epoch     (b_epoch),
        .cnt       (b_cnt)
    );

    typedef struct {
        logic       ready;
        logic       frst;
        logic       run;
        logic [6:0] key;
        logic [3:0] cnt;
        logic [0:0] ep;
        logic       cerr;
        logic       serr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model: keys, mask, run flag and edges elapsed since start.
    logic [6:0] m_key [N];
    logic [1:0] m_mask;
    bit         m_run;
    int         m_k;
    bit         m_cerr;
    bit         m_serr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_key[i] = '0;
        m_mask = '0;
        m_run  = 0;
        m_k    = 0;
        m_cerr = 0;
        m_serr = 0;
    endtask

    task automatic model_update(input logic v, input logic [0:0] idx, input logic [6:0] key,
                                input logic st, input logic sp);
        bit full;
        full   = (m_mask == 2'b11);
        m_cerr = 0;
        m_serr = 0;
        if (!m_run) begin
            if (v) begin
                if (32'(idx) < N) begin
                    m_key[idx]  = key;
                    m_mask[idx] = 1'b1;
                end else begin
                    m_cerr = 1;
                end
            end
            if (st && !sp) begin
                if (full) begin
                    m_run = 1;
                    m_k   = 0;
                end else begin
                    m_serr = 1;
                end
            end
        end else if (sp) begin
            m_run = 0;
            m_k   = 0;
        end else begin
            m_k++;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        int   pos;
        pos     = m_k % P;
        e.ready = !m_run;
        e.frst  = !m_run;
        e.run   = m_run;
        e.key   = m_run ? m_key[pos / L] : 7'd0;
        e.cnt   = m_run ? 4'(pos) : 4'd0;
        e.ep    = m_run ? 1'(pos / L) : 1'b0;
        e.cerr  = m_cerr;
        e.serr  = m_serr;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; inputs change 1 time unit after the posedge.
    task automatic step(input logic v, input logic [0:0] idx, input logic [6:0] key,
                        input logic st, input logic sp);
        cfg_valid = v;
        cfg_idx   = idx;
        cfg_key   = key;
        start     = st;
        stop      = sp;
        @(posedge clk);
        model_update(v, idx, key, st, sp);
        push_exp();
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    endtask

    // Reset asserted between edges while the design may be running.
    task automatic mid_reset();
        cfg_valid = 0;
        start     = 0;
        stop      = 0;
        @(posedge clk);
        model_update(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        push_exp();
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic b_step(input logic v, input logic [1:0] idx, input logic [3:0] key,
                          input logic st);
        b_valid = v;
        b_idx   = idx;
        b_key   = key;
        b_start = st;
        @(posedge clk);
        #1;
        b_valid = 0;
        b_start = 0;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cfg_ready", 32'(cfg_ready), 32'(e.ready));
                check("fsm_rst",   32'(fsm_rst),   32'(e.frst));
                check("running",   32'(running),   32'(e.run));
                check("key_out",   32'(key_out),   32'(e.key));
                check("cnt",       32'(cnt),       32'(e.cnt));
                check("epoch",     32'(epoch),     32'(e.ep));
                check("cfg_err",   32'(cfg_err),   32'(e.cerr));
                check("start_err", 32'(start_err), 32'(e.serr));
            end
        end
    end

    initial begin
        logic [3:0] b_keys [3];
        model_reset();
        push_exp();
        @(negedge clk);
        #2;
        rst = 1'b1;

        // Empty mask, then only slot 0 loaded: both starts must be refused.
        step(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 7'b0100001, 1'b0, 1'b0);
        step(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
        idle_steps(2);

        // Complete the mask and run through two full lock periods.
        step(1'b1, 1'b1, 7'b1101000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
        idle_steps(2 * P + 3);

        // Stop while cnt is 9, then restart without reloading.
        while ((m_k % P) != 9) idle_steps(1);
        step(1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
        idle_steps(2);
        step(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
        idle_steps(10);
        step(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 7'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 7'd0, 1'b1, 1'b1);
        idle_steps(1);

        // Randomised traffic including rewrites, same-edge write/start and stops.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 7'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0));
        end

        // Reset in the middle of a run clears keys and mask.
        step(1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 7'h55, 1'b0, 1'b0);
        step(1'b1, 1'b1, 7'h2a, 1'b0, 1'b0);
        step(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
        idle_steps(5);
        mid_reset();
        step(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
        idle_steps(2);

        // Out-of-range write on the three-epoch instance is discarded.
        b_step(1'b1, 2'd3, 4'hA, 1'b0);
        @(negedge clk);
        check("b_cfg_err_pulse", 32'(b_cfg_err), 32'd1);
        @(negedge clk);
        check("b_cfg_err_clear", 32'(b_cfg_err), 32'd0);
        b_step(1'b0, 2'd0, 4'h0, 1'b1);
        @(negedge clk);
        check("b_start_err", 32'(b_start_err), 32'd1);
        check("b_running_idle", 32'(b_running), 32'd0);

        b_keys[0] = 4'h1;
        b_keys[1] = 4'h6;
        b_keys[2] = 4'h8;
        for (int i = 0; i < 3; i++) b_step(1'b1, 2'(i), b_keys[i], 1'b0);
        b_step(1'b0, 2'd0, 4'h0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("b_key_out", 32'(b_key_out), 32'(b_keys[(k % 6) / 2]));
            check("b_cnt", 32'(b_cnt), 32'(k % 6));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lock_key_sequencer.md
# lock_key_sequencer

Time-varying key scheduler for the counter-windowed locked FSM benchmarks. It stores one key word per counter window (epoch) and owns the locked FSM's reset. Each key is presented on the FSM's key inputs exactly during the FSM counter window that expects it. It sits between the key-provisioning/config interface and the `keyinput*` pins of a locked benchmark instance, such as the 7-input/9-output knot-class controllers.

## Interface
Parameters:
- `KEY_W`, 7: key word width; equals the number of `keyinput` pins.
- `NUM_EPOCHS`, 2: number of key windows per lock period.
- `EPOCH_LEN`, 7: FSM clock cycles per window.
  - Lock period `P` = `NUM_EPOCHS*EPOCH_LEN`, 14 by default.

Ports:
- `clk`, in, 1: the single clock.
  - Block logic is posedge.
  - The locked FSM consumes `key_out` on negedge.
- `rst`, in, 1: asynchronous, active-low reset.
- `cfg_valid`, in, 1: key write request.
- `cfg_ready`, out, 1: write accepted when `cfg_valid && cfg_ready` at posedge.
- `cfg_idx`, in, `IDX_W` = max(1, clog2(`NUM_EPOCHS`)): epoch slot to write.
- `cfg_key`, in, `KEY_W`: key word.
  - Bit i drives `keyinput` i.
- `cfg_err`, out, 1: one-cycle pulse on an accepted write with `cfg_idx >= NUM_EPOCHS`. The data is discarded.
- `start`, in, 1: begin sequencing.
- `stop`, in, 1: abort sequencing.
- `start_err`, out, 1: one-cycle pulse when `start` is seen in IDLE with an incomplete slot mask.
- `key_out`, out, `KEY_W`: drives `keyinput0..KEY_W-1` of the locked FSM.
- `fsm_rst`, out, 1: active-high reset to the locked FSM.
- `running`, out, 1: high in RUN.
- `epoch`, out, `IDX_W`: current epoch index.
- `cnt`, out, `CNT_W` = clog2(`P`): position within the lock period.

## Operation
- Storage:
  - `NUM_EPOCHS` key registers of `KEY_W` bits.
  - A `NUM_EPOCHS`-bit loaded mask.
  - All cleared by reset.
- State machine, two states:
  - IDLE:
    - `cfg_ready`=1; `fsm_rst`=1; `key_out`=0; `cnt`=0; `epoch`=0.
    - An accepted write with an in-range index stores the key and sets its mask bit. Rewrites are allowed.
    - `start` with the registered mask all-ones (a same-cycle write is not counted) → RUN.
    - `start` with an incomplete mask → stays in IDLE and pulses `start_err`.
  - RUN:
    - `cfg_ready`=0; `fsm_rst`=0; `key_out` = `key[epoch]`.
    - `cnt` increments every posedge, wrapping `P-1`→0.
    - `epoch` = `cnt / EPOCH_LEN`, maintained as a separate counter that increments when the in-epoch count wraps at `EPOCH_LEN-1`. No divider.
    - `stop` → IDLE; `cnt` and `epoch` are cleared.
- Precedence:
  - `stop` over `start` when both are asserted in the same cycle.
  - In IDLE, `stop` alone is ignored.
  - `start` in RUN is ignored.
- Keys and mask persist across stop/start. Only reset clears them.
- `fsm_rst` reasserting on stop resynchronises the FSM counter.

## Timing
- Reset values:
  - `cfg_ready`=1, `fsm_rst`=1.
  - `key_out`, `cnt`, `epoch`, `running`, `cfg_err`, `start_err` all 0.
- All outputs are registered. They change only at posedge or at reset assertion.
- `start` accepted at posedge T:
  - From T: `running`=1, `fsm_rst`=0, `key_out`=`key[0]`.
  - The first FSM negedge after T sees counter 0 and `key[0]`.
- Alignment:
  - At the k-th negedge after T, `key_out` = `key[(k mod P)/EPOCH_LEN]`.
  - This equals the key expected for FSM counter `k mod P`.
- Key changes are half a cycle clear of the consuming negedge. This is zero-latency alignment with no skew cycle.
- `stop` at posedge S: from S, `fsm_rst`=1, `key_out`=0, `running`=0.
- Reset asserted mid-RUN: immediate return to reset values, and the key store and mask are cleared.

## Structure
- Shared package `lock_pkg`:
  - State enum (IDLE, RUN).
  - Default `KEY_W`, `NUM_EPOCHS`, `EPOCH_LEN`.
  - `IDX_W` and `CNT_W` helper functions.
- One natural sub-module: `lock_epoch_counter`.
  - Nested in-epoch counter (0..`EPOCH_LEN-1`) and epoch counter (0..`NUM_EPOCHS-1`) with wrap.
  - Produces `cnt` and `epoch`.
- The top level holds the key store, the mask, the FSM and the output registers.

## Test plan
- Reset and load:
  - Write `idx0`=7'b0100001 and `idx1`=7'b1101000, then `start`.
  - Expect `key_out`=7'b0100001 for 7 cycles, 7'b1101000 for 7 cycles, then repeat.
  - Expect `cnt` to wrap 13→0 and `epoch` to toggle every 7 cycles.
- Incomplete mask:
  - Write only `idx0`, then `start`.
  - Expect a `start_err` pulse, state stays IDLE, `fsm_rst`=1.
- Bad index:
  - Write with `cfg_idx`=1 when `NUM_EPOCHS`=1 (or an out-of-range value when `IDX_W` allows it).
  - Expect a `cfg_err` pulse and the mask unchanged.
- Stop/start:
  - `stop` at `cnt`=9, expect `fsm_rst`=1 and `key_out`=0 next.
  - Restart and expect sequencing from `cnt`=0 with `key[0]` and no reload.
  - Simultaneous `start` and `stop` in RUN → IDLE.
- Closed loop with a locked knot-class instance:
  - Apply correct keys; its outputs match the unlocked golden model over 200 random input vectors.
  - Apply a wrong `idx1` key; a divergence is observed within 14 cycles.
- Reset mid-RUN (`rst`=0 between edges):
  - Expect outputs at reset values immediately.
  - After reset, `start` yields `start_err`, because the mask is cleared.
